wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the WB pipeline stage and a
//  multi-cycle mul/div unit. WB always has priority. Mul/div results queue in a small
//  FIFO and drain into idle WB slots. A starved result forces one pipeline bubble.
//  Exports a pending-destination mask so the hazard unit can stall RAW readers.
// PARAMETERS
//  DEPTH     2  mul/div result FIFO entries (>=1)
//  MAX_WAIT  4  cycles a FIFO head may wait before a bubble is forced (>=1)
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  clrn          in   1   asynchronous active-low reset
//  WBwreg        in   1   WB stage write enable (from MEM/WB register)
//  WBwn          in   5   WB destination register
//  WBdata        in   32  WB write data (already m2reg-muxed)
//  md_valid      in   1   mul/div result valid
//  md_wn         in   5   mul/div destination register
//  md_data       in   32  mul/div result
//  md_ready      out  1   FIFO can accept this cycle (count < DEPTH)
//  rf_we         out  1   register-file write enable
//  rf_wn         out  5   register-file write address
//  rf_wd         out  32  register-file write data
//  stall_req     out  1   request that the hazard unit insert a bubble into MEM/WB next cycle
//  pending_mask  out  32  bit r = 1 while a valid FIFO entry targets register r
// BEHAVIOUR
//  - Reset (clrn=0, async): FIFO emptied, age=0, state=IDLE. While clrn=0: rf_we=0, rf_wn=0,
//    rf_wd=0, stall_req=0, md_ready=0, pending_mask=0. Reset mid-operation discards queued results.
//  - wb_req = WBwreg & (WBwn!=0). Writes to $0 never reach the register file.
//  - Port select (combinational, same cycle): if wb_req -> rf_we=1, rf_wn=WBwn, rf_wd=WBdata.
//    Else if FIFO non-empty -> pop head: rf_we=1, rf_wn/rf_wd = head. Else rf_we=0, rf_wn=0, rf_wd=0.
//  - Push: md_valid & md_ready -> enqueue at tail on the clock edge. md_wn=0 is accepted and dropped.
//    There is no bypass, so minimum latency from md_valid to rf_we is 1 cycle.
//  - Simultaneous push and pop: count unchanged. md_ready depends only on registered count.
//  - md_valid while md_ready=0: the producer must hold its result. It is not accepted.
//  - WAW squash: wb_req to register r invalidates every queued entry with wn==r, including an
//    entry accepted that same cycle. Invalid entries still occupy their slot. An invalid head
//    pops in an idle slot with rf_we=0 and without consuming the port.
//  - pending_mask: OR of one-hot(wn) over valid entries. Derived from registered state only.
//  - Age counter: reset to 0 on every pop and whenever the FIFO is empty. Otherwise increments
//    each cycle the head waits, saturating at MAX_WAIT.
//  - FSM (registered):
//      IDLE : FIFO empty. Go to PEND on push.
//      PEND : non-empty, stall_req=0. Go to IDLE when the last entry pops with no push.
//             Go to FORCE when the head is not popped and age==MAX_WAIT-1.
//      FORCE: stall_req=1. After the head pops, go to PEND if non-empty, else IDLE.
//             If wb_req persists (a contract violation), WB still wins and the FSM stays in FORCE.
//  - Order: FIFO order is strictly preserved. WB never stalls on account of this block.
// TESTING
//  1 Reset: clrn=0 mid-queue with 2 entries -> count=0, pending_mask=0, stall_req=0, rf_we=0
//    immediately (async).
//  2 Idle drain: WBwreg=0, md_valid=1 md_wn=5 md_data=32'hDEAD for 1 cycle -> next cycle rf_we=1,
//    rf_wn=5, rf_wd=32'hDEAD. pending_mask bit5 set for exactly 1 cycle.
//  3 Full/backpressure: WBwreg=1 WBwn=3 continuously, push wn=7 then wn=8 -> md_ready=0 after 2
//    pushes. A third md_valid is not accepted. pending_mask=32'h180.
//  4 Starvation: as test 3 with MAX_WAIT=4 -> stall_req rises 4 cycles after the first push.
//    Drop WBwreg for 1 cycle -> wn=7 written, age resets, stall_req falls.
//  5 WAW squash: queue wn=9, then WBwreg=1 WBwn=9 WBdata=1 -> pending_mask bit9 clears. The later
//    idle slot shows rf_we=0 and reg 9 keeps value 1.
//  6 $0 handling: md_wn=0 and WBwn=0 WBwreg=1 -> rf_we never asserted. Count unchanged after the drop.

Source files
------------

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Brief    : Shares the register-file write port between WB (priority) and a
//            queued mul/div result stream, with starvation bubble and
//            pending-destination mask.
// Revision : 1.0  initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        WBwreg,
  input  logic [4:0]  WBwn,
  input  logic [31:0] WBdata,
  input  logic        md_valid,
  input  logic [4:0]  md_wn,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        rf_we,
  output logic [4:0]  rf_wn,
  output logic [31:0] rf_wd,
  output logic        stall_req,
  output logic [31:0] pending_mask
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] C_DEPTH     = CW'(DEPTH);
  localparam logic [AW-1:0] C_AGE_LIMIT = AW'(MAX_WAIT);
  localparam logic [AW-1:0] C_FORCE_AGE = AW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    age_q, age_d;
  logic             stall_q, stall_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]       wn_q   [DEPTH];
  logic [4:0]       wn_d   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];

  logic             w_wb_req;
  logic             w_pop;
  logic             w_push;
  logic [CW-1:0]    w_wr_idx;
  logic [DEPTH-1:0] w_keep;

  assign w_wb_req = WBwreg & (WBwn != 5'd0);
  assign md_ready = clrn & (count_q < C_DEPTH);
  assign w_pop    = ~w_wb_req & (count_q != '0);
  // md_wn == 0 is handshaked but never stored.
  assign w_push   = md_valid & md_ready & (md_wn != 5'd0);
  assign w_wr_idx = w_pop ? (count_q - CW'(1)) : count_q;
  assign stall_req = stall_q;

  always_comb begin
    rf_we = 1'b0;
    rf_wn = 5'd0;
    rf_wd = 32'd0;
    if (clrn) begin
      if (w_wb_req) begin
        rf_we = 1'b1;
        rf_wn = WBwn;
        rf_wd = WBdata;
      end else if (count_q != '0) begin
        // A squashed head drains through the idle slot without writing.
        rf_we = valid_q[0];
        rf_wn = wn_q[0];
        rf_wd = data_q[0];
      end
    end
  end

  always_comb begin
    pending_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) pending_mask[wn_q[i]] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_keep[i] = valid_q[i] & ~(w_wb_req & (wn_q[i] == WBwn));
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wn_d[i]    = wn_q[i];
      data_d[i]  = data_q[i];
      valid_d[i] = w_keep[i];
    end
    if (w_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        wn_d[i]    = wn_q[i+1];
        data_d[i]  = data_q[i+1];
        valid_d[i] = w_keep[i+1];
      end
      valid_d[DEPTH-1] = 1'b0;
    end
    if (w_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == w_wr_idx) begin
          wn_d[i]    = md_wn;
          data_d[i]  = md_data;
          valid_d[i] = ~(w_wb_req & (md_wn == WBwn));
        end
      end
    end
  end

  always_comb begin
    count_d = count_q + CW'(w_push) - CW'(w_pop);

    age_d = age_q;
    if (w_pop || (count_q == '0)) begin
      age_d = '0;
    end else if (age_q != C_AGE_LIMIT) begin
      age_d = age_q + AW'(1);
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (count_d != '0) state_d = ST_PEND;
      ST_PEND: begin
        if (count_d == '0) begin
          state_d = ST_IDLE;
        end else if (!w_pop && (age_q == C_FORCE_AGE)) begin
          state_d = ST_FORCE;
        end
      end
      ST_FORCE: if (w_pop) state_d = (count_d != '0) ? ST_PEND : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    stall_d = (state_d == ST_FORCE);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      age_q   <= '0;
      stall_q <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      age_q   <= age_d;
      stall_q <= stall_d;
      valid_q <= valid_d;
    end
  end

  // Payload needs no reset: it is only observed behind count/valid.
  always_ff @(posedge clk) begin
    wn_q   <= wn_d;
    data_q <= data_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_wb_port_arbiter
// Brief    : Self-checking bench for wb_port_arbiter (vector table, directed
//            corner sequences, randomized run against a queue-based model).
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_port_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk, clrn;
  logic        WBwreg, md_valid;
  logic [4:0]  WBwn, md_wn;
  logic [31:0] WBdata, md_data;
  logic        md_ready, rf_we, stall_req;
  logic [4:0]  rf_wn;
  logic [31:0] rf_wd, pending_mask;

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .clrn(clrn),
    .WBwreg(WBwreg), .WBwn(WBwn), .WBdata(WBdata),
    .md_valid(md_valid), .md_wn(md_wn), .md_data(md_data),
    .md_ready(md_ready), .rf_we(rf_we), .rf_wn(rf_wn), .rf_wd(rf_wd),
    .stall_req(stall_req), .pending_mask(pending_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of queued results, a wait counter and a bubble flag.
  typedef struct packed {
    logic [4:0]  wn;
    logic [31:0] data;
    logic        valid;
  } ent_t;

  ent_t mq[$];
  int   m_age   = 0;
  bit   m_force = 1'b0;

  task automatic model_check(input string tag);
    logic        e_we, e_rdy, e_stall;
    logic [4:0]  e_wn;
    logic [31:0] e_wd, e_mask;
    e_we = 1'b0; e_rdy = 1'b0; e_stall = 1'b0; e_wn = 5'd0; e_wd = 32'd0; e_mask = 32'd0;
    if (clrn) begin
      e_rdy   = (mq.size() < DEPTH);
      e_stall = m_force;
      foreach (mq[i]) if (mq[i].valid) e_mask[mq[i].wn] = 1'b1;
      if (WBwreg && WBwn != 5'd0) begin
        e_we = 1'b1; e_wn = WBwn; e_wd = WBdata;
      end else if (mq.size() > 0) begin
        e_we = mq[0].valid; e_wn = mq[0].wn; e_wd = mq[0].data;
      end
    end
    chk({tag, "_rf_we"}, {31'd0, rf_we}, {31'd0, e_we});
    if (e_we || mq.size() == 0 || !clrn) begin
      chk({tag, "_rf_wn"}, {27'd0, rf_wn}, {27'd0, e_wn});
      chk({tag, "_rf_wd"}, rf_wd, e_wd);
    end
    chk({tag, "_md_ready"}, {31'd0, md_ready}, {31'd0, e_rdy});
    chk({tag, "_stall"}, {31'd0, stall_req}, {31'd0, e_stall});
    chk({tag, "_mask"}, pending_mask, e_mask);
  endtask

  task automatic model_step();
    bit   wbr, pop, push;
    int   n0;
    ent_t e;
    wbr  = WBwreg && (WBwn != 5'd0);
    n0   = mq.size();
    pop  = !wbr && n0 > 0;
    push = md_valid && (n0 < DEPTH) && (md_wn != 5'd0);
    if (m_force) m_force = !pop;
    else         m_force = (n0 > 0) && !pop && (m_age == MAX_WAIT - 1);
    if (pop || n0 == 0)      m_age = 0;
    else if (m_age < MAX_WAIT) m_age = m_age + 1;
    foreach (mq[i]) if (wbr && mq[i].wn == WBwn) mq[i].valid = 1'b0;
    if (pop) void'(mq.pop_front());
    if (push) begin
      e.wn = md_wn; e.data = md_data; e.valid = !(wbr && md_wn == WBwn);
      mq.push_back(e);
    end
  endtask

  task automatic drive(input logic wr, input logic [4:0] wn, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mwn, input logic [31:0] md);
    @(negedge clk);
    WBwreg = wr; WBwn = wn; WBdata = wd;
    md_valid = mv; md_wn = mwn; md_data = md;
    #1;
    model_check("model");
    model_step();
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic do_reset();
    @(negedge clk);
    md_valid = 1'b0;
    clrn = 1'b0;
    #1;
    mq.delete(); m_age = 0; m_force = 1'b0;
    model_check("rst");
    #2;
    clrn = 1'b1;
    #1;
    model_check("rst_rel");
    model_step();
  endtask

  typedef struct {
    logic        wr;   logic [4:0] wn;  logic [31:0] wd;
    logic        mv;   logic [4:0] mwn; logic [31:0] md;
    logic        e_we; logic [4:0] e_wn; logic [31:0] e_wd;
    logic        e_rdy; logic e_stall; logic [31:0] e_mask; logic e_chkd;
  } vec_t;

  function automatic vec_t mk(logic wr, logic [4:0] wn, logic [31:0] wd,
                              logic mv, logic [4:0] mwn, logic [31:0] md,
                              logic e_we, logic [4:0] e_wn, logic [31:0] e_wd,
                              logic e_rdy, logic e_stall, logic [31:0] e_mask, logic e_chkd);
    vec_t v;
    v.wr = wr; v.wn = wn; v.wd = wd; v.mv = mv; v.mwn = mwn; v.md = md;
    v.e_we = e_we; v.e_wn = e_wn; v.e_wd = e_wd;
    v.e_rdy = e_rdy; v.e_stall = e_stall; v.e_mask = e_mask; v.e_chkd = e_chkd;
    return v;
  endfunction

  vec_t vt[$];
  int   bias;

  initial begin
    clrn = 1'b0;
    WBwreg = 1'b1; WBwn = 5'd3; WBdata = 32'h1111_2222;
    md_valid = 1'b0; md_wn = 5'd0; md_data = 32'd0;
    #1;
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset_md_ready", {31'd0, md_ready}, 32'd0);
    chk("reset_mask", pending_mask, 32'd0);
    chk("reset_stall", {31'd0, stall_req}, 32'd0);
    WBwreg = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;

    //           wr  wn     wd            mv  mwn    md            we  wn     wd            rdy stl mask          chkd
    vt.push_back(mk(0, 5'd0,  32'd0,        0, 5'd0,  32'd0,        0, 5'd0,  32'd0,        1, 0, 32'h0,        1));
    vt.push_back(mk(0, 5'd0,  32'd0,        1, 5'd5,  32'hDEAD,     0, 5'd0,  32'd0,        1, 0, 32'h0,        1));
    vt.push_back(mk(0, 5'd0,  32'd0,        0, 5'd0,  32'd0,        1, 5'd5,  32'hDEAD,     1, 0, 32'h20,       1));
    vt.push_back(mk(0, 5'd0,  32'd0,        0, 5'd0,  32'd0,        0, 5'd0,  32'd0,        1, 0, 32'h0,        1));
    vt.push_back(mk(1, 5'd0,  32'h123,      1, 5'd0,  32'h55,       0, 5'd0,  32'd0,        1, 0, 32'h0,        1));
    vt.push_back(mk(0, 5'd0,  32'd0,        0, 5'd0,  32'd0,        0, 5'd0,  32'd0,        1, 0, 32'h0,        1));
    vt.push_back(mk(0, 5'd0,  32'd0,        1, 5'd9,  32'h99,       0, 5'd0,  32'd0,        1, 0, 32'h0,        1));
    vt.push_back(mk(1, 5'd9,  32'd1,        0, 5'd0,  32'd0,        1, 5'd9,  32'd1,        1, 0, 32'h200,      1));
    vt.push_back(mk(0, 5'd0,  32'd0,        0, 5'd0,  32'd0,        0, 5'd0,  32'd0,        1, 0, 32'h0,        0));
    vt.push_back(mk(0, 5'd0,  32'd0,        0, 5'd0,  32'd0,        0, 5'd0,  32'd0,        1, 0, 32'h0,        1));
    vt.push_back(mk(1, 5'd12, 32'd7,        1, 5'd12, 32'hAB,       1, 5'd12, 32'd7,        1, 0, 32'h0,        1));
    vt.push_back(mk(0, 5'd0,  32'd0,        0, 5'd0,  32'd0,        0, 5'd0,  32'd0,        1, 0, 32'h0,        0));
    vt.push_back(mk(0, 5'd0,  32'd0,        0, 5'd0,  32'd0,        0, 5'd0,  32'd0,        1, 0, 32'h0,        1));

    for (int k = 0; k < vt.size(); k++) begin
      drive(vt[k].wr, vt[k].wn, vt[k].wd, vt[k].mv, vt[k].mwn, vt[k].md);
      chk($sformatf("vec%0d_we", k), {31'd0, rf_we}, {31'd0, vt[k].e_we});
      if (vt[k].e_chkd) begin
        chk($sformatf("vec%0d_wn", k), {27'd0, rf_wn}, {27'd0, vt[k].e_wn});
        chk($sformatf("vec%0d_wd", k), rf_wd, vt[k].e_wd);
      end
      chk($sformatf("vec%0d_ready", k), {31'd0, md_ready}, {31'd0, vt[k].e_rdy});
      chk($sformatf("vec%0d_stall", k), {31'd0, stall_req}, {31'd0, vt[k].e_stall});
      chk($sformatf("vec%0d_mask", k), pending_mask, vt[k].e_mask);
    end

    // Backpressure and starvation under continuous WB traffic.
    drive(1, 5'd3, 32'h33, 1, 5'd7,  32'h77);
    drive(1, 5'd3, 32'h33, 1, 5'd8,  32'h88);
    drive(1, 5'd3, 32'h33, 1, 5'd10, 32'hAA);
    chk("full_ready", {31'd0, md_ready}, 32'd0);
    chk("full_mask", pending_mask, 32'h180);
    drive(1, 5'd3, 32'h33, 0, 5'd0, 32'd0);
    chk("starve_c3_stall", {31'd0, stall_req}, 32'd0);
    drive(1, 5'd3, 32'h33, 0, 5'd0, 32'd0);
    chk("starve_c4_stall", {31'd0, stall_req}, 32'd0);
    drive(1, 5'd3, 32'h33, 0, 5'd0, 32'd0);
    chk("starve_c5_stall", {31'd0, stall_req}, 32'd1);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("bubble_we", {31'd0, rf_we}, 32'd1);
    chk("bubble_wn", {27'd0, rf_wn}, 32'd7);
    chk("bubble_wd", rf_wd, 32'h77);
    drive(1, 5'd3, 32'h33, 0, 5'd0, 32'd0);
    chk("after_bubble_stall", {31'd0, stall_req}, 32'd0);
    chk("after_bubble_mask", pending_mask, 32'h100);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("drain2_wn", {27'd0, rf_wn}, 32'd8);
    chk("drain2_wd", rf_wd, 32'h88);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("drained_we", {31'd0, rf_we}, 32'd0);

    // Asynchronous reset with two queued entries and WB active.
    drive(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
    drive(1, 5'd3, 32'h33, 1, 5'd6, 32'h66);
    do_reset();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("post_reset_we", {31'd0, rf_we}, 32'd0);
    chk("post_reset_mask", pending_mask, 32'd0);

    bias = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) begin
        case ($urandom_range(0, 3))
          0:       bias = 10;
          1:       bias = 50;
          2:       bias = 90;
          default: bias = 100;
        endcase
      end
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        drive(($urandom_range(0, 99) < bias), 5'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
